imem_port_arbiter: RTL and testbench
====================================

# imem_port_arbiter

Shares the single-port, synchronous-read instruction BRAM between the pipeline's fetch port and the program-loader/debug port. It grants at most one access per cycle and drives the BRAM address, enable and write strobes. It returns read data one cycle after grant, tagged to the granted requester. Fetch addresses are range- and alignment-checked here, so a bad fetch never reaches the BRAM.

## Interface
- ADDR_W, 11: BRAM word-address width.
- BASE, 32'h00003000: first legal byte address.
- LIMIT, 32'h00004ffc: last legal word byte address.
- MAX_BURST, 4: consecutive loader grants allowed while fetch waits.
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- f_req  in  1  fetch request; held with f_addr until f_gnt.
- f_addr  in  32  fetch byte address.
- f_gnt  out  1  fetch accepted this cycle.
- f_valid  out  1  fetch response cycle.
- f_rdata  out  32  fetched word; 0 on error.
- f_err  out  1  fetch address error, qualified by f_valid.
- l_req  in  1  loader request; held with other l_* inputs until l_gnt.
- l_we  in  1  1 = write word, 0 = read.
- l_addr  in  32  loader byte address; only bits [ADDR_W+1:2] are used.
- l_wdata  in  32  loader write data.
- l_lock  in  1  while high, fetch is never granted.
- l_gnt  out  1  loader accepted this cycle.
- l_valid  out  1  loader response cycle; acknowledges writes too.
- l_rdata  out  32  read word; 0 for writes.
- ram_en  out  1  BRAM enable.
- ram_we  out  4  BRAM byte strobes; 4'b1111 on loader write, else 0.
- ram_addr  out  ADDR_W  BRAM word address.
- ram_wdata  out  32  BRAM write data.
- ram_rdata  in  32  BRAM read data, valid the cycle after ram_en.

## Operation
- **Fetch error check.** A fetch is an error when any of these holds: f_addr[1:0] != 0, f_addr < BASE, or f_addr > LIMIT.
- **Fetch address mapping.** ram_addr = (f_addr - BASE)[ADDR_W+1:2].
- **Erroneous fetch.** It is still granted and consumes the slot. It drives ram_en=0.
- **Arbitration (combinational from registered state and requests).**
  - Only one requesting and eligible: that one wins. Fetch is ineligible while l_lock=1.
  - Both requesting: loader wins unless burst_cnt == MAX_BURST, in which case fetch wins.
- **burst_cnt (saturating register).**
  - Increments when the loader is granted while f_req=1 and l_lock=0.
  - Clears on any fetch grant, or on any cycle with f_req=0.
- **Response tracking.** Registers `own` record the owner of each grant: NONE, FETCH, FETCH_ERR or LOAD_RD/LOAD_WR.
- **Response cycle (cycle after grant).**
  - FETCH: f_valid=1, f_rdata=ram_rdata, f_err=0.
  - FETCH_ERR: f_valid=1, f_rdata=0, f_err=1.
  - LOAD_RD: l_valid=1, l_rdata=ram_rdata.
  - LOAD_WR: l_valid=1, l_rdata=0.
  - NONE: all valids 0, data outputs 0.
- **Back-to-back grants** are allowed every cycle, to either side, in any order.
- **No request:** ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.

## Timing
- **Grant path.** f_gnt and l_gnt are combinational in the request cycle. They are forced 0 while reset=0. They are never both 1.
- **Latency.** Response is exactly 1 cycle after grant; there is no other latency.
- **While reset=0:** `own`=NONE and burst_cnt=0. All outputs are 0: f_gnt, f_valid, f_rdata, f_err, l_gnt, l_valid, l_rdata, ram_en, ram_we, ram_addr, ram_wdata.
- **Reset asserted mid-operation.** An in-flight response is dropped; no valid follows reset deassertion.
- **Requests during reset** are ignored. They must be re-presented after reset.
- **l_lock rising while a fetch response is in flight.** The response still completes next cycle. Only new fetch grants are blocked.
- **Simultaneous f_req and l_req at reset release.** Loader wins, because burst_cnt=0.
- **MAX_BURST boundary.** The (MAX_BURST+1)-th contending cycle grants fetch, then the counter restarts from 0.

## Test plan
- **Basic fetch.** Preload word 0x24080005 at index 0. f_req=1, f_addr=0x3000 → f_gnt same cycle, ram_addr=0. Next cycle f_valid=1, f_rdata=0x24080005, f_err=0.
- **Fetch errors.** f_addr=0x3002, 0x2ffc, then 0x5000 → each granted with ram_en=0. Next cycle f_valid=1, f_err=1, f_rdata=0. A following fetch at 0x4ffc returns index 0x7ff data with f_err=0.
- **Loader write then fetch.** l_req=1, l_we=1, l_addr=0x0010, l_wdata=0xDEADBEEF → ram_we=4'b1111, ram_addr=4. Next cycle l_valid=1, l_rdata=0. Then fetch at 0x3010 returns 0xDEADBEEF.
- **Contention and fairness.** Hold f_req=1 (0x3000) and l_req=1 (reads) continuously with MAX_BURST=4 → grants follow L,L,L,L,F,L,L,L,L,F. Each response goes to the correct port with the correct data.
- **Lock.** l_lock=1 and f_req=1 with no loader request for 10 cycles → f_gnt=0 throughout. Drop l_lock → f_gnt=1 that cycle.
- **Reset mid-operation.** Fetch granted at cycle N; reset=0 asynchronously in cycle N+1 before the edge → f_valid=0 immediately and all outputs 0. After release with no requests, f_valid and l_valid stay 0.

Source files
------------

// File: rtl/imem_port_arbiter_if.sv
// imem_port_arbiter_if
// Bundles the fetch port, the loader/debug port and the BRAM port of the
// instruction-memory arbiter.
//   slave  : arbiter view (takes requests and BRAM read data; drives grants,
//            responses and the BRAM controls)
//   master : environment view (pipeline fetch unit, loader, BRAM model)
// Fetch   : f_req, f_addr -> f_gnt, f_valid, f_rdata, f_err
// Loader  : l_req, l_we, l_addr, l_wdata, l_lock -> l_gnt, l_valid, l_rdata
// BRAM    : ram_en, ram_we, ram_addr, ram_wdata <- ram_rdata
interface imem_port_arbiter_if #(
   parameter int ADDR_W = 11
);
   logic              f_req;
   logic [31:0]       f_addr;
   logic              f_gnt;
   logic              f_valid;
   logic [31:0]       f_rdata;
   logic              f_err;

   logic              l_req;
   logic              l_we;
   logic [31:0]       l_addr;
   logic [31:0]       l_wdata;
   logic              l_lock;
   logic              l_gnt;
   logic              l_valid;
   logic [31:0]       l_rdata;

   logic              ram_en;
   logic [3:0]        ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;

   modport slave (
      input  f_req, f_addr,
      output f_gnt, f_valid, f_rdata, f_err,
      input  l_req, l_we, l_addr, l_wdata, l_lock,
      output l_gnt, l_valid, l_rdata,
      output ram_en, ram_we, ram_addr, ram_wdata,
      input  ram_rdata
   );

   modport master (
      output f_req, f_addr,
      input  f_gnt, f_valid, f_rdata, f_err,
      output l_req, l_we, l_addr, l_wdata, l_lock,
      input  l_gnt, l_valid, l_rdata,
      input  ram_en, ram_we, ram_addr, ram_wdata,
      output ram_rdata
   );
endinterface

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter
// Shares one single-port synchronous-read instruction BRAM between the
// pipeline fetch port and the program-loader/debug port. At most one access
// is granted per cycle; the response appears exactly one cycle later on the
// port that owned the grant. Fetch addresses are range/alignment checked so a
// bad fetch is answered with f_err and never touches the BRAM.
// Ports:
//   clk   : system clock, all state on posedge
//   reset : asynchronous, active-low; clears state and forces outputs to 0
//   bus   : imem_port_arbiter_if.slave (fetch, loader and BRAM signals)
module imem_port_arbiter #(
   parameter int          ADDR_W    = 11,
   parameter logic [31:0] BASE      = 32'h0000_3000,
   parameter logic [31:0] LIMIT     = 32'h0000_4ffc,
   parameter int          MAX_BURST = 4
) (
   input logic                 clk,
   input logic                 reset,
   imem_port_arbiter_if.slave  bus
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);

   localparam logic [2:0] OWN_NONE      = 3'd0;
   localparam logic [2:0] OWN_FETCH     = 3'd1;
   localparam logic [2:0] OWN_FETCH_ERR = 3'd2;
   localparam logic [2:0] OWN_LOAD_RD   = 3'd3;
   localparam logic [2:0] OWN_LOAD_WR   = 3'd4;

   logic [2:0]       own;
   logic [CNT_W-1:0] burst_cnt;
   logic             f_bad;
   logic             f_elig;
   logic             f_win;
   logic             l_win;
   logic [31:0]      f_offset;
   logic             unused_addr_bits;

   // Fetch address check and BRAM mapping relative to BASE.
   assign f_bad    = (bus.f_addr[1:0] != 2'b00) || (bus.f_addr < BASE) ||
                     (bus.f_addr > LIMIT);
   assign f_offset = bus.f_addr - BASE;
   assign f_elig   = bus.f_req && !bus.l_lock;

   assign unused_addr_bits = ^{f_offset[31:ADDR_W+2], f_offset[1:0],
                               bus.l_addr[31:ADDR_W+2], bus.l_addr[1:0]};

   // Loader normally wins contention; once it has taken MAX_BURST grants in
   // a row while fetch was waiting, fetch gets the next slot. Grants are
   // held off entirely while reset is asserted.
   always_comb begin
      f_win = 1'b0;
      l_win = 1'b0;
      if (reset) begin
         if (f_elig && bus.l_req) begin
            if (burst_cnt == CNT_W'(MAX_BURST)) begin
               f_win = 1'b1;
            end else begin
               l_win = 1'b1;
            end
         end else if (f_elig) begin
            f_win = 1'b1;
         end else if (bus.l_req) begin
            l_win = 1'b1;
         end
      end
   end

   assign bus.f_gnt = f_win;
   assign bus.l_gnt = l_win;

   // BRAM drive: a bad fetch still consumes the slot but leaves the BRAM
   // idle; write data is only presented for loader writes.
   always_comb begin
      bus.ram_en    = 1'b0;
      bus.ram_we    = 4'b0000;
      bus.ram_addr  = '0;
      bus.ram_wdata = 32'd0;
      if (f_win && !f_bad) begin
         bus.ram_en   = 1'b1;
         bus.ram_addr = f_offset[ADDR_W+1:2];
      end else if (l_win) begin
         bus.ram_en   = 1'b1;
         bus.ram_addr = bus.l_addr[ADDR_W+1:2];
         if (bus.l_we) begin
            bus.ram_we    = 4'b1111;
            bus.ram_wdata = bus.l_wdata;
         end
      end
   end

   // Consecutive loader grants while fetch is contending; saturates at
   // MAX_BURST and restarts whenever fetch is served or stops asking.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         burst_cnt <= '0;
      end else if (f_win || !bus.f_req) begin
         burst_cnt <= '0;
      end else if (l_win && !bus.l_lock && (burst_cnt != CNT_W'(MAX_BURST))) begin
         burst_cnt <= burst_cnt + CNT_W'(1);
      end
   end

   // Remember who owns the response of this cycle's grant.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         own <= OWN_NONE;
      end else if (f_win) begin
         own <= f_bad ? OWN_FETCH_ERR : OWN_FETCH;
      end else if (l_win) begin
         own <= bus.l_we ? OWN_LOAD_WR : OWN_LOAD_RD;
      end else begin
         own <= OWN_NONE;
      end
   end

   // Response steering; own is cleared asynchronously so everything here is
   // already 0 while reset is held.
   always_comb begin
      bus.f_valid = 1'b0;
      bus.f_err   = 1'b0;
      bus.f_rdata = 32'd0;
      bus.l_valid = 1'b0;
      bus.l_rdata = 32'd0;
      case (own)
         OWN_FETCH: begin
            bus.f_valid = 1'b1;
            bus.f_rdata = bus.ram_rdata;
         end
         OWN_FETCH_ERR: begin
            bus.f_valid = 1'b1;
            bus.f_err   = 1'b1;
         end
         OWN_LOAD_RD: begin
            bus.l_valid = 1'b1;
            bus.l_rdata = bus.ram_rdata;
         end
         OWN_LOAD_WR: begin
            bus.l_valid = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter
// Drives the arbiter with directed and randomized fetch/loader traffic, hosts
// a behavioural BRAM, and compares every output each cycle against a
// reference model built from the arbitration rules and a shadow memory.
module tb_imem_port_arbiter;

   localparam int          ADDR_W    = 11;
   localparam logic [31:0] BASE      = 32'h0000_3000;
   localparam logic [31:0] LIMIT     = 32'h0000_4ffc;
   localparam int          MAX_BURST = 4;
   localparam int          DEPTH     = 2048;

   logic clk = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   imem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

   imem_port_arbiter #(
      .ADDR_W(ADDR_W), .BASE(BASE), .LIMIT(LIMIT), .MAX_BURST(MAX_BURST)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   // Behavioural single-port synchronous-read BRAM.
   logic [31:0] mem [DEPTH];
   always @(posedge clk) begin
      if (bus.ram_en) begin
         if (bus.ram_we == 4'hF) begin
            mem[bus.ram_addr] <= bus.ram_wdata;
         end else begin
            bus.ram_rdata <= mem[bus.ram_addr];
         end
      end
   end

   // Reference model state.
   logic [31:0] refMem [DEPTH];
   int          refBurst;
   int          expKind;      // 0 none, 1 fetch, 2 fetch error, 3 load read, 4 load write
   logic [31:0] expData;
   logic        modelFWin, modelLWin;

   logic        curFReq, curLReq, curLWe, curLLock;
   logic [31:0] curFAddr, curLAddr, curLWdata;

   logic        obsFGnt, obsLGnt, obsFValid, obsFErr;
   logic [31:0] obsFRdata;

   int compared = 0;
   int mismatched = 0;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic fReq, input logic [31:0] fAddr,
                                input logic lReq, input logic lWe,
                                input logic [31:0] lAddr, input logic [31:0] lWdata,
                                input logic lLock);
      curFReq = fReq;  curFAddr = fAddr;
      curLReq = lReq;  curLWe = lWe;  curLAddr = lAddr;  curLWdata = lWdata;
      curLLock = lLock;
      bus.f_req = fReq;  bus.f_addr = fAddr;
      bus.l_req = lReq;  bus.l_we = lWe;  bus.l_addr = lAddr;
      bus.l_wdata = lWdata;  bus.l_lock = lLock;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_f_gnt"},     32'(bus.f_gnt),   32'd0);
      checkOutput({tag, "_l_gnt"},     32'(bus.l_gnt),   32'd0);
      checkOutput({tag, "_f_valid"},   32'(bus.f_valid), 32'd0);
      checkOutput({tag, "_f_err"},     32'(bus.f_err),   32'd0);
      checkOutput({tag, "_f_rdata"},   bus.f_rdata,      32'd0);
      checkOutput({tag, "_l_valid"},   32'(bus.l_valid), 32'd0);
      checkOutput({tag, "_l_rdata"},   bus.l_rdata,      32'd0);
      checkOutput({tag, "_ram_en"},    32'(bus.ram_en),  32'd0);
      checkOutput({tag, "_ram_we"},    32'(bus.ram_we),  32'd0);
      checkOutput({tag, "_ram_addr"},  32'(bus.ram_addr), 32'd0);
      checkOutput({tag, "_ram_wdata"}, bus.ram_wdata,    32'd0);
   endtask

   // Called just after a posedge with inputs applied; checks at the
   // following negedge, advances the model, and returns just after the next
   // posedge.
   task automatic stepCycle();
      logic        fBad, fElig;
      int unsigned fIdx, lIdx;
      logic        eEn;
      logic [3:0]  eWe;
      logic [31:0] eAddr, eWdata;
      @(negedge clk);
      obsFGnt = bus.f_gnt;  obsLGnt = bus.l_gnt;
      obsFValid = bus.f_valid;  obsFErr = bus.f_err;  obsFRdata = bus.f_rdata;

      // Response owed from the previous grant.
      checkOutput("f_valid", 32'(bus.f_valid), 32'((expKind == 1) || (expKind == 2)));
      checkOutput("f_err",   32'(bus.f_err),   32'(expKind == 2));
      checkOutput("f_rdata", bus.f_rdata,      (expKind == 1) ? expData : 32'd0);
      checkOutput("l_valid", 32'(bus.l_valid), 32'((expKind == 3) || (expKind == 4)));
      checkOutput("l_rdata", bus.l_rdata,      (expKind == 3) ? expData : 32'd0);

      // Arbitration from the rules.
      fBad  = (curFAddr % 4 != 0) || (curFAddr < BASE) || (curFAddr > LIMIT);
      fElig = curFReq && !curLLock;
      if (fElig && curLReq) begin
         modelFWin = (refBurst == MAX_BURST);
      end else begin
         modelFWin = fElig;
      end
      modelLWin = curLReq && !modelFWin;
      fIdx = ((curFAddr - BASE) / 4) % DEPTH;
      lIdx = (curLAddr / 4) % DEPTH;

      eEn = 1'b0;  eWe = 4'd0;  eAddr = 32'd0;  eWdata = 32'd0;
      if (modelFWin && !fBad) begin
         eEn = 1'b1;  eAddr = fIdx;
      end else if (modelLWin) begin
         eEn = 1'b1;  eAddr = lIdx;
         if (curLWe) begin
            eWe = 4'hF;  eWdata = curLWdata;
         end
      end
      checkOutput("f_gnt",     32'(bus.f_gnt),    32'(modelFWin));
      checkOutput("l_gnt",     32'(bus.l_gnt),    32'(modelLWin));
      checkOutput("ram_en",    32'(bus.ram_en),   32'(eEn));
      checkOutput("ram_we",    32'(bus.ram_we),   32'(eWe));
      checkOutput("ram_addr",  32'(bus.ram_addr), eAddr);
      checkOutput("ram_wdata", bus.ram_wdata,     eWdata);

      // Advance the model.
      if (modelFWin || !curFReq) begin
         refBurst = 0;
      end else if (modelLWin && !curLLock && refBurst < MAX_BURST) begin
         refBurst++;
      end
      expKind = 0;  expData = 32'd0;
      if (modelFWin) begin
         expKind = fBad ? 2 : 1;
         expData = fBad ? 32'd0 : refMem[fIdx];
      end else if (modelLWin) begin
         if (curLWe) begin
            expKind = 4;  refMem[lIdx] = curLWdata;
         end else begin
            expKind = 3;  expData = refMem[lIdx];
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      stepCycle();
   endtask

   initial begin
      logic        fPend, lPend;
      logic [31:0] v;
      for (int i = 0; i < DEPTH; i++) begin
         v = $urandom;
         mem[i] = v;
         refMem[i] = v;
      end
      mem[0] = 32'h2408_0005;
      refMem[0] = 32'h2408_0005;
      mem[11'h7ff] = 32'hC0DE_07FF;
      refMem[11'h7ff] = 32'hC0DE_07FF;
      bus.ram_rdata = 32'd0;
      refBurst = 0;  expKind = 0;  expData = 32'd0;

      // Reset with requests present: everything must stay 0.
      applyStimulus(1'b1, BASE, 1'b1, 1'b0, 32'h40, 32'd0, 1'b0);
      #1 reset = 1'b0;
      #11;
      checkAllZero("in_reset");

      // Release with both requesting: loader wins first.
      @(posedge clk);
      #1 reset = 1'b1;
      stepCycle();
      checkOutput("release_l_wins", 32'(obsLGnt), 32'd1);
      idleCycle();

      // Basic fetch.
      applyStimulus(1'b1, 32'h3000, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      stepCycle();
      checkOutput("basic_f_gnt", 32'(obsFGnt), 32'd1);
      idleCycle();
      checkOutput("basic_f_rdata", obsFRdata, 32'h2408_0005);

      // Fetch errors, then the last legal word.
      applyStimulus(1'b1, 32'h3002, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      stepCycle();
      applyStimulus(1'b1, 32'h2ffc, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      stepCycle();
      checkOutput("err_misalign_f_err", 32'(obsFErr), 32'd1);
      applyStimulus(1'b1, 32'h5000, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      stepCycle();
      applyStimulus(1'b1, 32'h4ffc, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      stepCycle();
      checkOutput("err_high_f_err", 32'(obsFErr), 32'd1);
      idleCycle();
      checkOutput("limit_f_rdata", obsFRdata, 32'hC0DE_07FF);

      // Loader write, then fetch it back.
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
      stepCycle();
      applyStimulus(1'b1, 32'h3010, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      stepCycle();
      idleCycle();
      checkOutput("wr_then_fetch", obsFRdata, 32'hDEAD_BEEF);

      // Contention: L,L,L,L,F repeating.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 32'h3000, 1'b1, 1'b0, 32'h20 + 32'(i * 4), 32'd0, 1'b0);
         stepCycle();
         checkOutput("contend_seq", 32'(obsFGnt), 32'((i % 5) == 4));
      end
      idleCycle();

      // Lock holds fetch off, release grants at once.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 32'h3008, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
         stepCycle();
      end
      applyStimulus(1'b1, 32'h3008, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      stepCycle();
      checkOutput("unlock_f_gnt", 32'(obsFGnt), 32'd1);

      // Lock rising while a fetch response is in flight.
      applyStimulus(1'b1, 32'h3000, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      stepCycle();
      checkOutput("lock_inflight_valid", 32'(obsFValid), 32'd1);
      idleCycle();

      // Reset mid-operation drops the in-flight response.
      applyStimulus(1'b1, 32'h3004, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      stepCycle();
      #1 reset = 1'b0;
      #1;
      checkAllZero("mid_reset");
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      refBurst = 0;  expKind = 0;  expData = 32'd0;
      @(posedge clk);
      #1 reset = 1'b1;
      stepCycle();
      stepCycle();

      // Randomized traffic; requests are held until the model grants them.
      fPend = 1'b0;  lPend = 1'b0;
      for (int i = 0; i < 400; i++) begin
         logic [31:0] fa, la, wd;
         logic        fr, lr, we, lk;
         fr = fPend;  lr = lPend;
         fa = curFAddr;  la = curLAddr;  we = curLWe;  wd = curLWdata;
         if (!fPend) begin
            fr = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 9))
               0: fa = BASE - 32'(4 * $urandom_range(1, 8));
               1: fa = LIMIT + 32'(4 * $urandom_range(1, 8));
               2: fa = BASE + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(1, 3));
               default: fa = BASE + 32'(4 * $urandom_range(0, 31));
            endcase
         end
         if (!lPend) begin
            lr = ($urandom_range(0, 1) == 1);
            we = ($urandom_range(0, 2) == 0);
            la = ($urandom & 32'hFFFF_E000) | 32'(4 * $urandom_range(0, 31));
            wd = $urandom;
         end
         lk = ($urandom_range(0, 7) == 0);
         applyStimulus(fr, fa, lr, we, la, wd, lk);
         stepCycle();
         fPend = fr && !modelFWin;
         lPend = lr && !modelLWin;
      end
      idleCycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
